pipeline_ctrl: RTL and testbench

- Hazard and pipeline-control unit for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
- Compares ID-stage source registers against EX- and MEM-stage destinations and generates operand-forwarding selects.
- Asserts a one-bubble stall on an EX-stage RAW hazard.
- Flushes the front end on a taken branch or jump.
- Purely combinational decision logic, gated by reset; it sits beside the pipeline registers and drives their stall and flush controls.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_ctrl_fwd_sel.sv | 29 ++
 rtl/pipeline_ctrl.sv | 84 ++++++++
 tb/tb_pipeline_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared constants for the hazard/pipeline-control unit
package pipeline_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_EX   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_e;

  localparam logic [REG_AW-1:0] REG_X0 = '0;

endpackage

// File: rtl/pipeline_ctrl_fwd_sel.sv
// rtl/pipeline_ctrl_fwd_sel.sv - operand-forwarding select for one ID source register
module fwd_sel
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  output logic [1:0]        sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ex_reg_write  && (ex_rd  != REG_X0) && (ex_rd  == rs);
  assign mem_hit = mem_reg_write && (mem_rd != REG_X0) && (mem_rd == rs);

  // The EX producer is younger than MEM, so its value wins when both match.
  always_comb begin
    sel = FWD_NONE;
    if (ex_hit) begin
      sel = FWD_EX;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - forwarding selects, load-use stall and branch/jump flush control
module pipeline_ctrl #(
  parameter int REG_AW = pipeline_ctrl_pkg::REG_AW,
  parameter int FWD_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              ex_reg_write,
  input  logic              mem_reg_write,
  input  logic              branch_taken,
  input  logic              jump,
  output logic [FWD_W-1:0]  forward_a,
  output logic [FWD_W-1:0]  forward_b,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush
);

  import pipeline_ctrl_pkg::*;

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       hz;
  logic       ctl;
  logic       unused_clk;

  // The decision logic is stateless; clk only keeps the port list uniform.
  assign unused_clk = clk;

  fwd_sel u_fwd_a (
    .rs            (id_rs1),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .sel           (sel_a)
  );

  fwd_sel u_fwd_b (
    .rs            (id_rs2),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .sel           (sel_b)
  );

  // No mem_read input exists, so every EX producer is treated as a load.
  assign hz  = ex_reg_write && (ex_rd != REG_X0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign ctl = branch_taken || jump;

  always_comb begin
    forward_a = FWD_W'(FWD_NONE);
    forward_b = FWD_W'(FWD_NONE);
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    if (rst_n) begin
      forward_a = FWD_W'(sel_a);
      forward_b = FWD_W'(sel_b);
      // A redirect squashes the stalled ID instruction, so the flush wins.
      if (ctl) begin
        if_flush = 1'b1;
        id_flush = 1'b1;
      end else if (hz) begin
        if_stall = 1'b1;
        id_stall = 1'b1;
        ex_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       ex_reg_write, mem_reg_write, branch_taken, jump;
  logic [1:0] forward_a, forward_b;
  logic       if_stall, id_stall, ex_stall, if_flush, id_flush, ex_flush;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_rd         (ex_rd),
    .mem_rd        (mem_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_reg_write (mem_reg_write),
    .branch_taken  (branch_taken),
    .jump          (jump),
    .forward_a     (forward_a),
    .forward_b     (forward_b),
    .if_stall      (if_stall),
    .id_stall      (id_stall),
    .ex_stall      (ex_stall),
    .if_flush      (if_flush),
    .id_flush      (id_flush),
    .ex_flush      (ex_flush)
  );

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       if_stall;
    logic       id_stall;
    logic       ex_stall;
    logic       if_flush;
    logic       id_flush;
    logic       ex_flush;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  // Producers listed youngest first; the select is 1 + position of the first live match.
  function automatic logic [1:0] pick(input logic [4:0] src, input logic [4:0] erd,
                                      input logic ewe, input logic [4:0] mrd, input logic mwe);
    logic [4:0] rds[2];
    logic       wes[2];
    rds[0] = erd; wes[0] = ewe;
    rds[1] = mrd; wes[1] = mwe;
    for (int k = 0; k < 2; k++)
      if (wes[k] && rds[k] != 5'd0 && rds[k] == src) return 2'(k + 1);
    return 2'd0;
  endfunction

  function automatic exp_t model(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] erd, input logic [4:0] mrd,
                                 input logic ewe, input logic mwe, input logic br, input logic jp);
    exp_t e;
    bit   load_use;
    e = '0;
    if (!rst) return e;
    e.fa = pick(rs1, erd, ewe, mrd, mwe);
    e.fb = pick(rs2, erd, ewe, mrd, mwe);
    load_use = ewe && erd != 5'd0 && (erd == rs1 || erd == rs2);
    if (br || jp) begin
      e.if_flush = 1'b1;
      e.id_flush = 1'b1;
    end else if (load_use) begin
      e.if_stall = 1'b1;
      e.id_stall = 1'b1;
      e.ex_flush = 1'b1;
    end
    return e;
  endfunction

  task automatic drive(input string nm, input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] erd, input logic [4:0] mrd, input logic ewe, input logic mwe,
                       input logic br, input logic jp);
    @(posedge clk);
    #1;
    rst_n = rst; id_rs1 = rs1; id_rs2 = rs2; ex_rd = erd; mem_rd = mrd;
    ex_reg_write = ewe; mem_reg_write = mwe; branch_taken = br; jump = jp;
    exp_q.push_back(model(rst, rs1, rs2, erd, mrd, ewe, mwe, br, jp));
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  got;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      got = {forward_a, forward_b, if_stall, id_stall, ex_stall, if_flush, id_flush, ex_flush};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL %s: got fa=%b fb=%b ifs=%b ids=%b exs=%b iff=%b idf=%b exf=%b, want fa=%b fb=%b ifs=%b ids=%b exs=%b iff=%b idf=%b exf=%b",
                 nm, got.fa, got.fb, got.if_stall, got.id_stall, got.ex_stall, got.if_flush, got.id_flush, got.ex_flush,
                 e.fa, e.fb, e.if_stall, e.id_stall, e.ex_stall, e.if_flush, e.id_flush, e.ex_flush);
      end
    end
  end

  initial begin
    rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0; mem_rd = '0;
    ex_reg_write = 1'b0; mem_reg_write = 1'b0; branch_taken = 1'b0; jump = 1'b0;

    //      name           rst rs1 rs2 exrd memrd ewe mwe br jp
    drive("reset",         0, 1,  0,  1,   0,    1,  0,  1, 0);
    drive("reset_release", 1, 1,  0,  1,   0,    1,  0,  1, 0);
    drive("ex_fwd",        1, 1,  2,  1,   0,    1,  0,  0, 0);
    drive("mem_fwd",       1, 1,  2,  0,   2,    0,  1,  0, 0);
    drive("priority",      1, 5,  0,  5,   5,    1,  1,  0, 0);
    drive("x0_no_fwd",     1, 0,  0,  0,   0,    1,  1,  0, 0);
    drive("we_low",        1, 7,  7,  7,   7,    0,  0,  0, 0);
    drive("load_use",      1, 3,  4,  3,   0,    1,  0,  0, 0);
    drive("rs2_hz",        1, 6,  9,  9,   6,    1,  1,  0, 0);
    drive("branch_flush",  1, 3,  4,  3,   0,    1,  0,  1, 0);
    drive("jump_flush",    1, 3,  4,  3,   0,    1,  0,  0, 1);
    drive("jump_no_hz",    1, 8,  9,  1,   2,    1,  1,  0, 1);
    drive("reset_again",   0, 3,  3,  3,   3,    1,  1,  0, 1);

    for (int i = 0; i < 400; i++) begin
      drive("random", ($urandom_range(0, 15) != 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
